mul_writeback_arbiter: RTL and testbench
========================================

// Module: mul_writeback_arbiter
// PURPOSE
//   Consumer end of the pipelined multiplier: accepts completed multiply results
//   (inst_decoded_t, fixed latency, no backpressure) and single-cycle ALU results
//   (valid/ready). Merges them into one register-file write port. Buffers colliding
//   multiply results in a small FIFO and throttles multiply issue so the FIFO never overflows.
// PARAMETERS
//   MUL_LATENCY  5  cycles from mul_issue to the result appearing on inst_mul_in
//   FIFO_DEPTH   4  multiply-result buffer entries (power of 2, >= 2)
//   STARVE_LIMIT 3  consecutive ALU denials before the ALU is granted one cycle
// PORTS
//   clk            in   1             clock
//   rst            in   1             asynchronous, active-high reset
//   mul_issue      in   1             a multiply enters the multiplier this cycle
//   inst_mul_in    in   inst_decoded_t  multiplier result; valid when .reg_data_ready=1
//   inst_alu_in    in   inst_decoded_t  ALU result; valid when .reg_data_ready=1
//   alu_ready      out  1             ALU result accepted this cycle (combinational)
//   mul_stall      out  1             issue stage must not assert mul_issue
//   rf_we          out  1             register-file write enable (registered)
//   rf_waddr       out  REG_ADDR_LEN  destination register (registered)
//   rf_wdata       out  ARCH_LEN      write data (registered)
// BEHAVIOUR
//   Reset: rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty, in-flight shift register 0,
//     starve counter 0. alu_ready=0 and mul_stall=0 while rst is high.
//   Sources per cycle, in priority order:
//     1 FIFO head, if FIFO not empty
//     2 incoming mul (bypass), if FIFO empty and inst_mul_in valid
//     3 ALU
//   Starvation rule: if the ALU has been valid and denied for STARVE_LIMIT consecutive
//     cycles, the ALU wins this cycle. Any incoming mul is pushed to the FIFO that cycle.
//   Mul results are never dropped. A valid inst_mul_in that does not win the port is
//     pushed at the same edge. Push and pop in the same cycle are legal; count is unchanged.
//   alu_ready = ALU valid && ALU wins. Un-accepted ALU results are held by the ALU.
//   Winner registered: rf_we=1, rf_waddr=.dst_reg, rf_wdata=.dst_reg_data at the next edge.
//     Latency: bypass mul or ALU is 1 cycle; a buffered mul is 1 cycle after reaching head.
//   x0 rule: dst_reg==0 still wins and consumes the slot, but drives rf_we=0.
//   In-flight tracking:
//     - MUL_LATENCY-bit shift register of mul_issue; inflight = popcount.
//     - mul_stall = (fifo_count + inflight) >= FIFO_DEPTH - 1. This reserves one slot for
//       the worst case where the FIFO head and the ALU starve-grant collide.
//   Overflow: a push while full is a design error. Assert it in simulation.
//     The RTL drops nothing silently. The count saturates, and the sticky flag
//     dbg_overflow is kept internal.
//   Starve counter:
//     - increments when ALU is valid and not granted; clears on grant or when ALU is not valid
//     - width $clog2(STARVE_LIMIT+1)
//   FIFO pointers wrap modulo FIFO_DEPTH. Full/empty is decided by a count register,
//     not by pointer compare.
//   Reset mid-operation flushes the FIFO, in-flight record and output register.
//     No write is issued in the cycle after rst deasserts.
// STRUCTURE
//   structure_pkg: reuse inst_decoded_t. Add wb_entry_t {dst_reg, dst_reg_data}.
//   constants_pkg: ARCH_LEN, REG_ADDR_LEN (existing). Add MUL_LATENCY_C=5 as the default source.
//   Sub-module: wb_result_fifo. Parameterised DEPTH and wb_entry_t. Ports: push, pop, din,
//     dout, count, full, empty. Async reset.
//   Top: arbitration, starve counter, in-flight shift register, output register.
// TESTING
//   1 Lone mul: valid, dst=5, data=0x12 -> next cycle rf_we=1, waddr=5, wdata=0x12;
//     FIFO stays empty.
//   2 Collision: mul(dst=3,0xAA) and ALU(dst=4,0xBB) in the same cycle -> mul writes first;
//     ALU wins the next cycle with alu_ready=1; each write takes 1 cycle.
//   3 Back-to-back mul: 4 consecutive mul results while the ALU is continuously valid.
//     The ALU is granted on the 4th cycle (STARVE_LIMIT=3), and that mul is buffered.
//     Remaining muls then drain in order and none are lost.
//   4 Throttle: issue muls every cycle -> mul_stall asserts once fifo_count+inflight reaches 3.
//     A full-FIFO assertion never fires across 1000 random cycles.
//   5 x0: ALU result dst=0, data=0xFF -> alu_ready=1 and rf_we stays 0.
//   6 Reset: assert rst with 2 FIFO entries and 3 in-flight -> all outputs 0 and count 0.
//     No stale write follows after release.

Source files
------------

// File: rtl/mul_writeback_arbiter_pkg.sv
// Shared types and constants for the multiplier write-back path.
// Pure declarations: no latency, no state.
// inst_decoded_t carries a result plus its valid bit (reg_data_ready).
package mul_writeback_arbiter_pkg;

    localparam int ARCH_LEN      = 32;
    localparam int REG_ADDR_LEN  = 5;
    localparam int MUL_LATENCY_C = 5;

    typedef struct packed {
        logic                    reg_data_ready;
        logic [REG_ADDR_LEN-1:0] dst_reg;
        logic [ARCH_LEN-1:0]     dst_reg_data;
    } inst_decoded_t;

    typedef struct packed {
        logic [REG_ADDR_LEN-1:0] dst_reg;
        logic [ARCH_LEN-1:0]     dst_reg_data;
    } wb_entry_t;

    // Strip the valid bit so only the write-back payload is stored.
    function automatic wb_entry_t to_wb_entry(input inst_decoded_t inst);
        wb_entry_t e;
        e.dst_reg      = inst.dst_reg;
        e.dst_reg_data = inst.dst_reg_data;
        return e;
    endfunction

endpackage

// File: rtl/mul_writeback_arbiter_fifo.sv
// Small FIFO buffering multiply results that lost the register-file port.
// Head is visible combinationally on dout; a push is readable the cycle after.
// No backpressure: a push while full (without a pop) is ignored and count saturates.
module wb_result_fifo
    import mul_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  wb_entry_t                  din,
    output wb_entry_t                  dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t      mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push-while-full is legal then.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally (DEPTH is a power of two); occupancy lives in count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mul_writeback_arbiter.sv
// Merges fixed-latency multiply results and valid/ready ALU results into one RF write port.
// Latency: bypass mul or ALU writes 1 cycle after arrival; buffered mul 1 cycle after reaching FIFO head.
// Multiply side has no backpressure (throttled at issue via mul_stall); ALU is held off via alu_ready.
module mul_writeback_arbiter
    import mul_writeback_arbiter_pkg::*;
#(
    parameter int MUL_LATENCY  = MUL_LATENCY_C,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mul_issue,
    input  inst_decoded_t           inst_mul_in,
    input  inst_decoded_t           inst_alu_in,
    output logic                    alu_ready,
    output logic                    mul_stall,
    output logic                    rf_we,
    output logic [REG_ADDR_LEN-1:0] rf_waddr,
    output logic [ARCH_LEN-1:0]     rf_wdata
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int IW = $clog2(MUL_LATENCY+1);
    localparam int SW = $clog2(STARVE_LIMIT+1);
    localparam int TW = ((CW > IW) ? CW : IW) + 1;

    logic              mul_vld;
    logic              alu_vld;
    logic              starve;
    logic              alu_win;
    logic              head_win;
    logic              bypass_win;
    logic              win_vld;
    wb_entry_t         win_entry;
    logic              fifo_push;
    logic              fifo_pop;
    wb_entry_t         fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [MUL_LATENCY-1:0] issue_sr;
    logic [IW-1:0]     inflight;
    logic [TW-1:0]     occupancy;
    logic [SW-1:0]     starve_cnt;
    logic              overflow_now;
    logic              dbg_overflow;

    assign mul_vld = inst_mul_in.reg_data_ready;
    assign alu_vld = inst_alu_in.reg_data_ready;
    assign starve  = alu_vld && (starve_cnt >= SW'(STARVE_LIMIT));

    // Pick this cycle's winner: starved ALU, then FIFO head, then bypass mul, then ALU.
    always_comb begin
        alu_win    = 1'b0;
        head_win   = 1'b0;
        bypass_win = 1'b0;
        win_entry  = fifo_dout;
        if (starve)           alu_win    = 1'b1;
        else if (!fifo_empty) head_win   = 1'b1;
        else if (mul_vld)     bypass_win = 1'b1;
        else if (alu_vld)     alu_win    = 1'b1;
        if (alu_win)         win_entry = to_wb_entry(inst_alu_in);
        else if (bypass_win) win_entry = to_wb_entry(inst_mul_in);
        win_vld = alu_win || head_win || bypass_win;
    end

    // Any valid mul that does not take the port directly is buffered at the same edge.
    assign fifo_push = mul_vld && !bypass_win;
    assign fifo_pop  = head_win;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (to_wb_entry(inst_mul_in)),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Count multiplies still inside the multiplier pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            inflight = inflight + IW'(issue_sr[i]);
        end
    end

    // One slot is held back for the cycle where a FIFO head and a starve grant collide.
    assign occupancy = TW'(fifo_count) + TW'(inflight);
    assign mul_stall = !rst && (occupancy >= TW'(FIFO_DEPTH - 1));
    assign alu_ready = !rst && alu_win;

    // Track issued multiplies over the last MUL_LATENCY cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) issue_sr <= '0;
        else     issue_sr <= {issue_sr[MUL_LATENCY-2:0], mul_issue};
    end

    // Count consecutive cycles a valid ALU result was refused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    starve_cnt <= '0;
        else if (alu_vld && !alu_win) starve_cnt <= starve_cnt + 1'b1;
        else                        starve_cnt <= '0;
    end

    // Register the winner; x0 still consumes the slot but never writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= win_vld && (win_entry.dst_reg != '0);
            if (win_vld) begin
                rf_waddr <= win_entry.dst_reg;
                rf_wdata <= win_entry.dst_reg_data;
            end
        end
    end

    assign overflow_now = fifo_push && fifo_full && !fifo_pop;

    // Sticky record that a multiply result could not be buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               dbg_overflow <= 1'b0;
        else if (overflow_now) dbg_overflow <= 1'b1;
    end

    // Flag the overflow in simulation; the throttle should make this unreachable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!dbg_overflow) else $error("multiply result FIFO overflowed");
        end
    end

endmodule

// File: tb/tb_mul_writeback_arbiter.sv
module tb_mul_writeback_arbiter;
    import mul_writeback_arbiter_pkg::*;

    typedef struct packed {
        logic [REG_ADDR_LEN-1:0] a;
        logic [ARCH_LEN-1:0]     d;
    } wr_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    mul_issue = 1'b0;
    inst_decoded_t           mul_in = '0;
    inst_decoded_t           alu_in = '0;
    logic                    alu_ready;
    logic                    mul_stall;
    logic                    rf_we;
    logic [REG_ADDR_LEN-1:0] rf_waddr;
    logic [ARCH_LEN-1:0]     rf_wdata;

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];
    wr_t exp_mul_q[$];

    always #5 clk = ~clk;

    mul_writeback_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .mul_issue   (mul_issue),
        .inst_mul_in (mul_in),
        .inst_alu_in (alu_in),
        .alu_ready   (alu_ready),
        .mul_stall   (mul_stall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    function automatic inst_decoded_t mk(input logic v, input int a, input logic [ARCH_LEN-1:0] d);
        inst_decoded_t r;
        r.reg_data_ready = v;
        r.dst_reg        = REG_ADDR_LEN'(a);
        r.dst_reg_data   = d;
        return r;
    endfunction

    function automatic wr_t mkw(input int a, input logic [ARCH_LEN-1:0] d);
        wr_t w;
        w.a = REG_ADDR_LEN'(a);
        w.d = d;
        return w;
    endfunction

    // Scoreboard: data bit 31 set marks a tagged multiply stream, otherwise the ordered queue.
    always @(posedge clk) begin
        wr_t got;
        wr_t e;
        #1;
        if (rf_we === 1'b1) begin
            got.a = rf_waddr;
            got.d = rf_wdata;
            total++;
            if (rf_wdata[31]) begin
                if (exp_mul_q.size() == 0) begin
                    bad++; $display("FAIL sb_mul unexpected write got a=%0d d=%h", got.a, got.d);
                end else begin
                    e = exp_mul_q.pop_front();
                    if (got !== e) begin
                        bad++; $display("FAIL sb_mul got a=%0d d=%h want a=%0d d=%h", got.a, got.d, e.a, e.d);
                    end
                end
            end else begin
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL sb_ord unexpected write got a=%0d d=%h", got.a, got.d);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++; $display("FAIL sb_ord got a=%0d d=%h want a=%0d d=%h", got.a, got.d, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        alu_in    = mk(1'b1, 6, 32'h66);
        mul_issue = 1'b1;
        @(negedge clk); #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", rf_we); end
        total++; if (rf_waddr !== '0) begin bad++; $display("FAIL rst_waddr got=%0d want=0", rf_waddr); end
        total++; if (rf_wdata !== '0) begin bad++; $display("FAIL rst_wdata got=%h want=0", rf_wdata); end
        total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL rst_alu_ready got=%b want=0", alu_ready); end
        total++; if (mul_stall !== 1'b0) begin bad++; $display("FAIL rst_mul_stall got=%b want=0", mul_stall); end
        @(negedge clk);
        alu_in = '0; mul_issue = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_release_we got=%b want=0", rf_we); end
    endtask

    task automatic test_lone_mul();
        @(negedge clk);
        mul_in = mk(1'b1, 5, 32'h12);
        exp_q.push_back(mkw(5, 32'h12));
        #1;
        total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL lone_alu_ready got=%b want=0", alu_ready); end
        @(posedge clk); #1;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL lone_we got=%b want=1", rf_we); end
        total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL lone_waddr got=%0d want=5", rf_waddr); end
        total++; if (rf_wdata !== 32'h12) begin bad++; $display("FAIL lone_wdata got=%h want=12", rf_wdata); end
        total++; if (dut.fifo_count !== '0) begin bad++; $display("FAIL lone_fifo got=%0d want=0", dut.fifo_count); end
        @(negedge clk);
        mul_in = '0;
        @(posedge clk); #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL lone_idle_we got=%b want=0", rf_we); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        mul_in = mk(1'b1, 3, 32'hAA);
        alu_in = mk(1'b1, 4, 32'hBB);
        exp_q.push_back(mkw(3, 32'hAA));
        exp_q.push_back(mkw(4, 32'hBB));
        #1;
        total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL col_rdy0 got=%b want=0", alu_ready); end
        @(posedge clk); #1;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAA) begin
            bad++; $display("FAIL col_mul got we=%b a=%0d d=%h want we=1 a=3 d=aa", rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        mul_in = '0;
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL col_rdy1 got=%b want=1", alu_ready); end
        @(posedge clk); #1;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hBB) begin
            bad++; $display("FAIL col_alu got we=%b a=%0d d=%h want we=1 a=4 d=bb", rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        alu_in = '0;
        @(posedge clk); #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL col_idle_we got=%b want=0", rf_we); end
    endtask

    task automatic test_back_to_back();
        int exp_a[5] = '{10, 11, 12, 7, 13};
        exp_q.push_back(mkw(10, 32'h100));
        exp_q.push_back(mkw(11, 32'h101));
        exp_q.push_back(mkw(12, 32'h102));
        exp_q.push_back(mkw(7,  32'h77));
        exp_q.push_back(mkw(13, 32'h103));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) mul_in = mk(1'b1, 10 + i, 32'h100 + 32'(i));
            else       mul_in = '0;
            alu_in = (i < 4) ? mk(1'b1, 7, 32'h77) : '0;
            #1;
            total++; if (alu_ready !== (i == 3)) begin
                bad++; $display("FAIL b2b_rdy[%0d] got=%b want=%b", i, alu_ready, (i == 3));
            end
            @(posedge clk); #1;
            total++; if (rf_we !== 1'b1 || rf_waddr !== 5'(exp_a[i])) begin
                bad++; $display("FAIL b2b_waddr[%0d] got we=%b a=%0d want we=1 a=%0d", i, rf_we, rf_waddr, exp_a[i]);
            end
            if (i == 3) begin
                total++; if (dut.fifo_count !== 3'd1) begin bad++; $display("FAIL b2b_fifo3 got=%0d want=1", dut.fifo_count); end
            end
        end
        total++; if (dut.fifo_count !== '0) begin bad++; $display("FAIL b2b_fifo_drained got=%0d want=0", dut.fifo_count); end
        @(negedge clk);
        @(posedge clk); #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL b2b_idle_we got=%b want=0", rf_we); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        alu_in = mk(1'b1, 0, 32'hFF);
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL x0_rdy got=%b want=1", alu_ready); end
        @(posedge clk); #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_we got=%b want=0", rf_we); end
        @(negedge clk);
        alu_in = '0;
        @(posedge clk); #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_after_we got=%b want=0", rf_we); end
    endtask

    task automatic test_throttle();
        logic [4:0] hist = '0;
        wr_t        pend_q[$];
        wr_t        e;
        logic       issue;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (hist[4]) begin
                e = pend_q.pop_front();
                mul_in = mk(1'b1, int'(e.a), e.d);
                exp_mul_q.push_back(e);
            end else begin
                mul_in = '0;
            end
            #1;
            total++; if (mul_stall !== ($countones(hist) >= 3)) begin
                bad++; $display("FAIL thr_stall[%0d] got=%b want=%b", cyc, mul_stall, ($countones(hist) >= 3));
            end
            total++; if (dut.fifo_count !== '0) begin bad++; $display("FAIL thr_fifo[%0d] got=%0d want=0", cyc, dut.fifo_count); end
            issue = (cyc < 20) && !mul_stall;
            if (issue) pend_q.push_back(mkw(1 + (cyc % 31), {1'b1, 31'(cyc + 32'h500)}));
            mul_issue = issue;
            hist = {hist[3:0], issue};
        end
        @(negedge clk);
        mul_in = '0; mul_issue = 1'b0;
        @(posedge clk); #1;
        total++; if (exp_mul_q.size() != 0 || pend_q.size() != 0) begin
            bad++; $display("FAIL thr_drain got=%0d/%0d want=0/0", exp_mul_q.size(), pend_q.size());
        end
    endtask

    task automatic test_random();
        logic [4:0]    hist = '0;
        wr_t           pend_q[$];
        wr_t           e;
        logic          issue;
        logic          alu_pend = 1'b0;
        inst_decoded_t alu_cur = '0;
        int            deny = 0;
        for (int cyc = 0; cyc < 1020; cyc++) begin
            @(negedge clk);
            if (hist[4]) begin
                e = pend_q.pop_front();
                mul_in = mk(1'b1, int'(e.a), e.d);
                exp_mul_q.push_back(e);
            end else begin
                mul_in = '0;
            end
            if (!alu_pend && cyc < 1000 && $urandom_range(0, 1) == 1) begin
                alu_pend = 1'b1;
                alu_cur  = mk(1'b1, int'($urandom_range(0, 31)), {1'b0, 31'($urandom)});
            end
            alu_in = alu_pend ? alu_cur : '0;
            #1;
            if ($countones(hist) >= 3) begin
                total++; if (mul_stall !== 1'b1) begin bad++; $display("FAIL rnd_stall[%0d] got=%b want=1", cyc, mul_stall); end
            end
            if (alu_pend && deny == 3) begin
                total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL rnd_starve[%0d] got=%b want=1", cyc, alu_ready); end
            end
            if (!alu_pend) begin
                total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL rnd_rdy_idle[%0d] got=%b want=0", cyc, alu_ready); end
            end
            if (alu_pend && alu_ready === 1'b1) begin
                if (alu_cur.dst_reg != '0) exp_q.push_back(mkw(int'(alu_cur.dst_reg), alu_cur.dst_reg_data));
                alu_pend = 1'b0;
                deny = 0;
            end else if (alu_pend) begin
                deny++;
            end else begin
                deny = 0;
            end
            issue = (cyc < 1000) && !mul_stall && ($urandom_range(0, 3) != 0);
            if (issue) pend_q.push_back(mkw(int'($urandom_range(1, 31)), {1'b1, 31'($urandom)}));
            mul_issue = issue;
            hist = {hist[3:0], issue};
        end
        @(negedge clk);
        mul_in = '0; alu_in = '0; mul_issue = 1'b0;
        @(posedge clk); #1;
        total++; if (exp_q.size() != 0 || exp_mul_q.size() != 0 || pend_q.size() != 0) begin
            bad++; $display("FAIL rnd_drain got=%0d/%0d/%0d want=0/0/0", exp_q.size(), exp_mul_q.size(), pend_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int ai = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            mul_in    = mk(1'b1, 21 + c, 32'h300 + 32'(c));
            alu_in    = mk(1'b1, 20, 32'h200 + 32'(ai));
            mul_issue = (c >= 5);
            if (c == 3 || c == 7) exp_q.push_back(mkw(20, 32'h200 + 32'(ai)));
            else if (c < 3)       exp_q.push_back(mkw(21 + c, 32'h300 + 32'(c)));
            else                  exp_q.push_back(mkw(20 + c, 32'h300 + 32'(c - 1)));
            #1;
            total++; if (alu_ready !== (c == 3 || c == 7)) begin
                bad++; $display("FAIL mid_rdy[%0d] got=%b want=%b", c, alu_ready, (c == 3 || c == 7));
            end
            if (alu_ready === 1'b1) ai++;
        end
        @(negedge clk);
        mul_in = '0; alu_in = '0; mul_issue = 1'b0;
        #1;
        total++; if (dut.fifo_count !== 3'd2) begin bad++; $display("FAIL mid_fifo_pre got=%0d want=2", dut.fifo_count); end
        total++; if (mul_stall !== 1'b1) begin bad++; $display("FAIL mid_stall_pre got=%b want=1", mul_stall); end
        rst = 1'b1;
        #1;
        total++; if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
            bad++; $display("FAIL mid_rst_out got we=%b a=%0d d=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        total++; if (dut.fifo_count !== '0) begin bad++; $display("FAIL mid_rst_fifo got=%0d want=0", dut.fifo_count); end
        total++; if (mul_stall !== 1'b0 || alu_ready !== 1'b0) begin
            bad++; $display("FAIL mid_rst_ctl got stall=%b rdy=%b want 0/0", mul_stall, alu_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_stale_we[%0d] got=%b want=0", c, rf_we); end
            total++; if (mul_stall !== 1'b0) begin bad++; $display("FAIL mid_post_stall[%0d] got=%b want=0", c, mul_stall); end
        end
        @(negedge clk);
        alu_in = mk(1'b1, 9, 32'h99);
        exp_q.push_back(mkw(9, 32'h99));
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL mid_alu_rdy got=%b want=1", alu_ready); end
        @(posedge clk); #1;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
            bad++; $display("FAIL mid_alu_wr got we=%b a=%0d want we=1 a=9", rf_we, rf_waddr);
        end
        @(negedge clk);
        alu_in = '0;
    endtask

    initial begin
        test_reset();
        test_lone_mul();
        test_collision();
        test_back_to_back();
        test_x0();
        test_throttle();
        test_random();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
